// File: rtl/ame_num_norm_pipe.sv
// Multi-lane signed divide-by-2^shift normaliser: 2-stage valid/ready pipeline.
// Optional AME_NUM_NORM_ROUND_EN: symmetric mode rounds half away from zero.
module ame_num_norm_pipe #(
  parameter int unsigned DATA_BITS  = 64,
  parameter int unsigned LANES      = 4,
  parameter int unsigned SHIFT_BITS = $clog2(DATA_BITS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       in_mode_i,
  input  logic [SHIFT_BITS-1:0]      in_shift_i,
  input  logic [LANES*DATA_BITS-1:0] in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [LANES*DATA_BITS-1:0] out_data_o,
  output logic                       busy_o
);

  localparam int unsigned BUS_BITS = LANES * DATA_BITS;

  logic                  s1_valid;
  logic                  s1_mode;
  logic [SHIFT_BITS-1:0] s1_shift;
  logic [LANES-1:0]      s1_sign;
  logic [DATA_BITS-1:0]  s1_val [LANES];

  logic                  s2_adv;
  logic                  s1_load;
  logic                  s1_valid_nxt;
  logic                  out_valid_nxt;
  logic [LANES-1:0]      cap_sign;
  logic [DATA_BITS-1:0]  cap_val [LANES];
  logic [DATA_BITS-1:0]  mag_res [LANES];
  logic [BUS_BITS-1:0]   res_bus;
`ifdef AME_NUM_NORM_ROUND_EN
  logic [DATA_BITS:0]    rnd_sum [LANES];
`endif

  // Handshake: ready depends on downstream accept only, never on in_valid_i.
  assign s2_adv        = !out_valid_o || out_ready_i;
  assign in_ready_o    = !s1_valid || s2_adv;
  assign s1_load       = in_valid_i && in_ready_o;
  assign s1_valid_nxt  = in_ready_o ? in_valid_i : s1_valid;
  assign out_valid_nxt = s2_adv ? s1_valid : out_valid_o;

  // Capture: magnitude for symmetric mode (|-2^(N-1)| fits unsigned), raw value for floor.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      cap_sign[k] = in_data_i[k*DATA_BITS + DATA_BITS - 1];
      cap_val[k]  = in_data_i[k*DATA_BITS +: DATA_BITS];
      if (!in_mode_i && cap_sign[k]) begin
        cap_val[k] = -in_data_i[k*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s1_valid_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (s1_load) begin
      s1_mode  <= in_mode_i;
      s1_shift <= in_shift_i;
      s1_sign  <= cap_sign;
      for (int k = 0; k < LANES; k++) begin
        s1_val[k] <= cap_val[k];
      end
    end
  end

  // Shift: arithmetic for floor, logical on magnitude then re-sign for symmetric.
  always_comb begin
    res_bus = '0;
    for (int k = 0; k < LANES; k++) begin
      mag_res[k] = '0;
`ifdef AME_NUM_NORM_ROUND_EN
      rnd_sum[k] = {1'b0, s1_val[k]};
      if (s1_shift != '0) begin
        rnd_sum[k] = rnd_sum[k] + ((DATA_BITS+1)'(1) << (s1_shift - SHIFT_BITS'(1)));
      end
`endif
      if (s1_mode) begin
        res_bus[k*DATA_BITS +: DATA_BITS] = DATA_BITS'($signed(s1_val[k]) >>> s1_shift);
      end else begin
`ifdef AME_NUM_NORM_ROUND_EN
        mag_res[k] = DATA_BITS'(rnd_sum[k] >> s1_shift);
`else
        mag_res[k] = s1_val[k] >> s1_shift;
`endif
        res_bus[k*DATA_BITS +: DATA_BITS] = s1_sign[k] ? -mag_res[k] : mag_res[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      out_valid_o <= out_valid_nxt;
      busy_o      <= s1_valid_nxt | out_valid_nxt;
      if (s2_adv && s1_valid) begin
        out_data_o <= res_bus;
      end
    end
  end

endmodule

// File: tb/tb_ame_num_norm_pipe.sv
// Self-checking bench for ame_num_norm_pipe: directed cases plus random streams
// checked against a division-based reference model.
module tb_ame_num_norm_pipe;

  localparam int unsigned DB = 64;
  localparam int unsigned LN = 4;
  localparam int unsigned SB = 6;
  localparam int unsigned W  = LN * DB;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [SB-1:0] in_shift;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] expq[$];

  ame_num_norm_pipe dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_mode_i  (in_mode),
    .in_shift_i (in_shift),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input longint a, input longint b, input longint c, input longint d);
    return {64'(d), 64'(c), 64'(b), 64'(a)};
  endfunction

  // Reference: exact division of the integer value by 2^s, then rounding rule.
  function automatic logic [DB-1:0] ref_lane(input logic [DB-1:0] x, input logic m, input int s);
    logic signed [127:0] xx, d, q, r, a;
    xx = {{64{x[DB-1]}}, x};
    d  = 128'sd1 << s;
    if (m) begin
      q = xx / d;
      r = xx % d;
      if (r != 0 && xx < 0) q = q - 1;
    end else begin
      a = (xx < 0) ? -xx : xx;
`ifdef AME_NUM_NORM_ROUND_EN
      if (s > 0) a = a + d / 2;
`endif
      q = a / d;
      if (xx < 0) q = -q;
    end
    return q[DB-1:0];
  endfunction

  function automatic logic [W-1:0] ref_beat(input logic m, input logic [SB-1:0] s, input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int k = 0; k < LN; k++) r[k*DB +: DB] = ref_lane(d[k*DB +: DB], m, int'(s));
    return r;
  endfunction

  // One beat through an idle pipeline with out_ready high; checks 2-cycle latency.
  task automatic directed(input string tag, input logic m, input int s, input logic [W-1:0] d,
                          input logic [W-1:0] exp);
    in_valid = 1'b1; in_mode = m; in_shift = SB'(s); in_data = d; out_ready = 1'b1;
    #1 check({tag, " rdy"}, W'(in_ready), W'(1));
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    check({tag, " lat1"}, W'(out_valid), W'(0));
    @(posedge clk); @(negedge clk);
    check({tag, " vld"}, W'(out_valid), W'(1));
    check(tag, out_data, exp);
    @(posedge clk); @(negedge clk);
  endtask

  // Random stream against the scoreboard; full=1 forces valid and ready every cycle.
  task automatic stream(input int nbeats, input bit full, output int cycles);
    int sent = 0;
    bit held = 1'b0;
    logic [W-1:0] held_data = '0;
    cycles = 0;
    while ((sent < nbeats || expq.size() > 0) && cycles < 500) begin
      if (sent < nbeats && (full || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_mode  = 1'($urandom);
        in_shift = SB'($urandom);
        in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
      out_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (held) begin
        check("stall vld", W'(out_valid), W'(1));
        check("stall data", out_data, held_data);
      end
      check("busy", W'(busy), W'(expq.size() > 0));
      check("in_ready", W'(in_ready), W'(!(expq.size() == 2 && !out_ready)));
      held = out_valid && !out_ready;
      held_data = out_data;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("spurious out", W'(out_valid), W'(0));
        else check("stream data", out_data, expq.pop_front());
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_beat(in_mode, in_shift, in_data));
        sent++;
      end
      @(posedge clk); @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    check("stream done", W'(cycles < 500), W'(1));
  endtask

  initial begin
    int cyc;
    logic [W-1:0] d;
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_shift = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst out_valid", W'(out_valid), W'(0));
    check("rst busy", W'(busy), W'(0));
    check("rst in_ready", W'(in_ready), W'(1));
    check("rst out_data", out_data, '0);

`ifdef AME_NUM_NORM_ROUND_EN
    directed("sym s2", 1'b0, 2, pk(7, -7, -8, 5), pk(2, -2, -2, 1));
    directed("round s2", 1'b0, 2, pk(6, -6, 5, -5), pk(2, -2, 1, -1));
`else
    directed("sym s2", 1'b0, 2, pk(7, -7, -8, 5), pk(1, -1, -2, 1));
`endif
    directed("floor s2", 1'b1, 2, pk(7, -7, -8, 5), pk(1, -2, -2, 1));

    d = pk(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, -1, 1);
    directed("sym s63", 1'b0, 63, d, ref_beat(1'b0, SB'(63), d));
    directed("floor s63", 1'b1, 63, d, pk(-1, 0, -1, 0));
    directed("sym s0 min", 1'b0, 0, d, d);
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    directed("sym s0", 1'b0, 0, d, d);
    directed("floor s0", 1'b1, 0, d, d);
`ifndef AME_NUM_NORM_ROUND_EN
    check("sym s63 lane0", pk(64'h8000_0000_0000_0000, 0, 0, 0) & '1 ^ '0,
          pk(64'h8000_0000_0000_0000, 0, 0, 0));
`endif

    stream(8, 1'b0, cyc);
    stream(8, 1'b1, cyc);
    check("throughput cycles", W'(cyc), W'(10));
    stream(8, 1'b0, cyc);

    // Fill with a stalled sink, then reset mid-stream.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_mode = 1'b0; in_shift = SB'(1);
      in_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(posedge clk); @(negedge clk);
    end
    check("full in_ready", W'(in_ready), W'(0));
    check("full busy", W'(busy), W'(1));
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("midrst out_valid", W'(out_valid), W'(0));
    check("midrst busy", W'(busy), W'(0));
    check("midrst out_data", out_data, '0);
    expq.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("post rst idle", W'(out_valid), W'(0));
    end
    stream(8, 1'b0, cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
